ex_stage_fwd: RTL and testbench
===============================

Name: ex_stage_fwd

Overview:
- Parametrised next-generation execute stage for the pipelined RISC-V core.
- Sits between the ID/EX and EX/MEM registers. Adds:
  - operand forwarding muxes;
  - full branch/jump resolution (pc_src, JALR target);
  - flush (bubble) support;
  - an iterative multi-cycle MUL unit with a busy/stall handshake.
- Owns the EX/MEM pipeline register.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- REG_ADDR_W, 5, register index width.
- MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL behaves as ADD, ex_busy is tied 0.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- regwrite_e  in  1  register write enable.
- result_src_e  in  2  writeback select.
- memwrite_e  in  1  memory write enable.
- jump_e  in  1  JAL/JALR.
- jalr_e  in  1  jump target = rs1-based.
- branch_e  in  1  conditional branch.
- funct3_e  in  3  branch compare type.
- alu_control_e  in  4  ALU operation.
- alu_src_e  in  1  operand B select: 1 = immediate.
- rs1_data_e, rs2_data_e  in  XLEN  register file read data.
- pc_e, pc_plus_4_e, immediate_e  in  XLEN  PC, PC+4, immediate.
- rd_e  in  REG_ADDR_W  destination register.
- forward_a_e, forward_b_e  in  2  forwarding select: 00 = regfile, 01 = wb_result_w, 10 = ex_mem_alu_result.
- wb_result_w  in  XLEN  writeback-stage result.
- flush_e  in  1  kill the instruction currently in EX.
- pc_src_e  out  1  redirect fetch (combinational).
- pc_target_e  out  XLEN  redirect target (combinational).
- ex_busy  out  1  stall F/D/E (combinational).
- ex_mem_alu_result, ex_mem_writedata, ex_mem_pc_plus_4  out  XLEN  EX/MEM register.
- ex_mem_rd  out  REG_ADDR_W  EX/MEM register.
- ex_mem_regwrite, ex_mem_memwrite  out  1  EX/MEM register.
- ex_mem_result_src  out  2  EX/MEM register.

Behaviour:
- Forwarding:
  - src_a = mux(forward_a_e) over rs1_data_e / wb_result_w / ex_mem_alu_result; code 11 selects rs1_data_e.
  - src_b is formed the same way from rs2_data_e.
  - operand_b = alu_src_e ? immediate_e : src_b.
  - Store data is src_b (forwarded), never the immediate.
- ALU codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLT (signed), 0110 SLTU, giving 1 or 0 zero-extended.
  - 0111 SLL, 1000 SRL, 1001 SRA; shift amount is operand_b[log2(XLEN)-1:0].
  - 1010 MUL (low XLEN bits of the product, multi-cycle).
  - Other codes give 0.
  - All arithmetic wraps modulo 2^XLEN.
- Branch compare (src_a vs src_b), by funct3_e:
  - 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
  - 010/011 never taken.
- Redirect:
  - pc_src_e = ~flush_e & ~ex_busy & (jump_e | (branch_e & taken)).
  - pc_target_e = jalr_e ? ((src_a + immediate_e) & ~1) : (pc_e + immediate_e).
- MUL FSM (states IDLE, BUSY, DONE; radix-2 shift-add):
  - IDLE: a non-flushed instruction with alu_control_e = 1010 asserts ex_busy the same cycle. At the edge, latch multiplicand = src_a, multiplier = operand_b, acc = 0, cnt = 0, go to BUSY.
  - BUSY: each cycle, if multiplier[0] then acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, cnt++. At cnt = XLEN-1 go to DONE.
  - DONE: ex_busy = 0 and the ALU result is acc. At the edge, go to IDLE; the still-held MUL must not retrigger.
  - ex_busy is high for exactly XLEN+1 cycles: the issue cycle plus XLEN BUSY cycles. The result enters EX/MEM at the end of the DONE cycle.
  - Upstream holds all *_e inputs stable while ex_busy = 1.
  - Forwarding selects may change during BUSY; operands are already latched.
  - flush_e in any state: FSM goes to IDLE next edge, ex_busy drops the same cycle, no result is produced.
- EX/MEM register:
  - On each edge, load a bubble if flush_e | ex_busy. A bubble is regwrite = 0, memwrite = 0, all other fields 0.
  - Otherwise load the computed values.
- Reset (reset_n = 0, asynchronous):
  - Every EX/MEM output is 0.
  - FSM goes to IDLE; acc, cnt and the operand latches are 0.
  - ex_busy = 0 while in reset.
  - Reset in mid-MUL abandons the operation.

Test Plan:
- ADD, forward_a = 10, ex_mem_alu_result = 7, rs2 = 5, alu_src = 0 -> next edge ex_mem_alu_result = 12, regwrite passes through.
- SW, forward_b = 01, wb_result_w = 0xDEADBEEF, imm = 8, rs1 = 0x100 -> ex_mem_alu_result = 0x108, ex_mem_writedata = 0xDEADBEEF, memwrite = 1.
- BLT with src_a = -1, src_b = 1, pc = 0x40, imm = 0x10 -> pc_src_e = 1, target = 0x50. The same compare with BLTU -> pc_src_e = 0.
- JALR, rs1 = 0x203, imm = 4 -> target = 0x206, pc_src = 1, ex_mem_alu_result = pc_plus_4.
- MUL 0xFFFF_FFFF × 3 -> ex_busy high 33 cycles, bubbles meanwhile, then ex_mem_alu_result = 0xFFFF_FFFD, regwrite = 1, exactly once.
- MUL with flush_e at BUSY cycle 10 -> ex_busy drops immediately, bubble loaded. reset_n low mid-MUL -> all outputs 0 asynchronously, FSM IDLE.

Source files
------------

// File: rtl/ex_stage_fwd.sv
// Execute stage: forwarding muxes, ALU, branch/jump resolution, iterative
// shift-add multiplier with a stall handshake, and the EX/MEM pipeline register.
module ex_stage_fwd #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MUL_EN     = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  regwrite_e,
    input  logic [1:0]            result_src_e,
    input  logic                  memwrite_e,
    input  logic                  jump_e,
    input  logic                  jalr_e,
    input  logic                  branch_e,
    input  logic [2:0]            funct3_e,
    input  logic [3:0]            alu_control_e,
    input  logic                  alu_src_e,
    input  logic [XLEN-1:0]       rs1_data_e,
    input  logic [XLEN-1:0]       rs2_data_e,
    input  logic [XLEN-1:0]       pc_e,
    input  logic [XLEN-1:0]       pc_plus_4_e,
    input  logic [XLEN-1:0]       immediate_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic [1:0]            forward_a_e,
    input  logic [1:0]            forward_b_e,
    input  logic [XLEN-1:0]       wb_result_w,
    input  logic                  flush_e,
    output logic                  pc_src_e,
    output logic [XLEN-1:0]       pc_target_e,
    output logic                  ex_busy,
    output logic [XLEN-1:0]       ex_mem_alu_result,
    output logic [XLEN-1:0]       ex_mem_writedata,
    output logic [XLEN-1:0]       ex_mem_pc_plus_4,
    output logic [REG_ADDR_W-1:0] ex_mem_rd,
    output logic                  ex_mem_regwrite,
    output logic                  ex_mem_memwrite,
    output logic [1:0]            ex_mem_result_src
);

    localparam int SHW  = $clog2(XLEN);
    localparam int CNTW = $clog2(XLEN);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_MUL  = 4'b1010;

    // Operand forwarding: index 0 is operand A (rs1), index 1 is operand B (rs2).
    logic [XLEN-1:0] rf_data [2];
    logic [1:0]      fwd_sel [2];
    logic [XLEN-1:0] fwd_src [2];

    assign rf_data[0] = rs1_data_e;
    assign rf_data[1] = rs2_data_e;
    assign fwd_sel[0] = forward_a_e;
    assign fwd_sel[1] = forward_b_e;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_fwd
            assign fwd_src[gi] = (fwd_sel[gi] == 2'b01) ? wb_result_w :
                                 (fwd_sel[gi] == 2'b10) ? ex_mem_alu_result :
                                                          rf_data[gi];
        end
    endgenerate

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] operand_b;
    logic [SHW-1:0]  shamt;

    assign src_a     = fwd_src[0];
    assign src_b     = fwd_src[1];
    assign operand_b = alu_src_e ? immediate_e : src_b;
    assign shamt     = operand_b[SHW-1:0];

    logic            mul_busy;
    logic [XLEN-1:0] mul_acc;

    logic [XLEN-1:0] alu_result;
    always_comb begin
        alu_result = '0;
        case (alu_control_e)
            ALU_ADD:  alu_result = src_a + operand_b;
            ALU_SUB:  alu_result = src_a - operand_b;
            ALU_AND:  alu_result = src_a & operand_b;
            ALU_OR:   alu_result = src_a | operand_b;
            ALU_XOR:  alu_result = src_a ^ operand_b;
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(operand_b))};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (src_a < operand_b)};
            ALU_SLL:  alu_result = src_a << shamt;
            ALU_SRL:  alu_result = src_a >> shamt;
            ALU_SRA:  alu_result = $unsigned($signed(src_a) >>> shamt);
            ALU_MUL:  alu_result = (MUL_EN != 0) ? mul_acc : (src_a + operand_b);
            default:  alu_result = '0;
        endcase
    end

    // Jumps write the link address back through the ALU result path.
    logic [XLEN-1:0] exec_result;
    assign exec_result = jump_e ? pc_plus_4_e : alu_result;

    logic taken;
    always_comb begin
        taken = 1'b0;
        case (funct3_e)
            3'b000:  taken = (src_a == src_b);
            3'b001:  taken = (src_a != src_b);
            3'b100:  taken = ($signed(src_a) <  $signed(src_b));
            3'b101:  taken = ($signed(src_a) >= $signed(src_b));
            3'b110:  taken = (src_a <  src_b);
            3'b111:  taken = (src_a >= src_b);
            default: taken = 1'b0;
        endcase
    end

    logic [XLEN-1:0] jalr_sum;
    assign jalr_sum    = src_a + immediate_e;
    assign pc_target_e = jalr_e ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_e + immediate_e);

    // Stall is forced low during reset even if a MUL sits on the inputs.
    assign ex_busy  = reset_n & mul_busy;
    assign pc_src_e = ~flush_e & ~ex_busy & (jump_e | (branch_e & taken));

    generate
        if (MUL_EN != 0) begin : gen_mul
            typedef enum logic [1:0] {
                ST_IDLE = 2'b00,
                ST_BUSY = 2'b01,
                ST_DONE = 2'b10
            } mul_state_t;

            mul_state_t      state_reg, state_next;
            logic [XLEN-1:0] mcand_reg, mcand_next;
            logic [XLEN-1:0] mplier_reg, mplier_next;
            logic [XLEN-1:0] acc_reg, acc_next;
            logic [CNTW-1:0] cnt_reg, cnt_next;
            logic            busy_c;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state_reg  <= ST_IDLE;
                    mcand_reg  <= '0;
                    mplier_reg <= '0;
                    acc_reg    <= '0;
                    cnt_reg    <= '0;
                end else begin
                    state_reg  <= state_next;
                    mcand_reg  <= mcand_next;
                    mplier_reg <= mplier_next;
                    acc_reg    <= acc_next;
                    cnt_reg    <= cnt_next;
                end
            end

            always_comb begin
                state_next  = state_reg;
                mcand_next  = mcand_reg;
                mplier_next = mplier_reg;
                acc_next    = acc_reg;
                cnt_next    = cnt_reg;
                busy_c      = 1'b0;
                case (state_reg)
                    ST_IDLE: begin
                        if (alu_control_e == ALU_MUL) begin
                            busy_c      = 1'b1;
                            state_next  = ST_BUSY;
                            mcand_next  = src_a;
                            mplier_next = operand_b;
                            acc_next    = '0;
                            cnt_next    = '0;
                        end
                    end
                    ST_BUSY: begin
                        busy_c = 1'b1;
                        if (mplier_reg[0]) begin
                            acc_next = acc_reg + mcand_reg;
                        end
                        mcand_next  = mcand_reg << 1;
                        mplier_next = mplier_reg >> 1;
                        cnt_next    = cnt_reg + 1'b1;
                        if (cnt_reg == CNTW'(XLEN-1)) begin
                            state_next = ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        // Result is consumed this cycle; never re-issue the held MUL.
                        state_next = ST_IDLE;
                    end
                    default: state_next = ST_IDLE;
                endcase
                if (flush_e) begin
                    state_next = ST_IDLE;
                    busy_c     = 1'b0;
                end
            end

            assign mul_busy = busy_c;
            assign mul_acc  = acc_reg;
        end else begin : gen_no_mul
            assign mul_busy = 1'b0;
            assign mul_acc  = '0;
        end
    endgenerate

    // EX/MEM register; a flushed or stalled cycle inserts an all-zero bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_mem_alu_result <= '0;
            ex_mem_writedata  <= '0;
            ex_mem_pc_plus_4  <= '0;
            ex_mem_rd         <= '0;
            ex_mem_regwrite   <= 1'b0;
            ex_mem_memwrite   <= 1'b0;
            ex_mem_result_src <= 2'b00;
        end else if (flush_e || ex_busy) begin
            ex_mem_alu_result <= '0;
            ex_mem_writedata  <= '0;
            ex_mem_pc_plus_4  <= '0;
            ex_mem_rd         <= '0;
            ex_mem_regwrite   <= 1'b0;
            ex_mem_memwrite   <= 1'b0;
            ex_mem_result_src <= 2'b00;
        end else begin
            ex_mem_alu_result <= exec_result;
            ex_mem_writedata  <= src_b;
            ex_mem_pc_plus_4  <= pc_plus_4_e;
            ex_mem_rd         <= rd_e;
            ex_mem_regwrite   <= regwrite_e;
            ex_mem_memwrite   <= memwrite_e;
            ex_mem_result_src <= result_src_e;
        end
    end

endmodule

// File: tb/tb_ex_stage_fwd.sv
// Bench for ex_stage_fwd: vector table for single-cycle ops and branches,
// scoreboard of expected EX/MEM contents, hand sequences for MUL, flush, reset.
module tb_ex_stage_fwd;

    logic        clk;
    logic        reset_n;
    logic        regwrite_e, memwrite_e, jump_e, jalr_e, branch_e, alu_src_e, flush_e;
    logic [1:0]  result_src_e, forward_a_e, forward_b_e;
    logic [2:0]  funct3_e;
    logic [3:0]  alu_control_e;
    logic [31:0] rs1_data_e, rs2_data_e, pc_e, pc_plus_4_e, immediate_e, wb_result_w;
    logic [4:0]  rd_e;
    logic        pc_src_e, ex_busy;
    logic [31:0] pc_target_e, ex_mem_alu_result, ex_mem_writedata, ex_mem_pc_plus_4;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_regwrite, ex_mem_memwrite;
    logic [1:0]  ex_mem_result_src;

    ex_stage_fwd #(.XLEN(32), .REG_ADDR_W(5), .MUL_EN(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .regwrite_e(regwrite_e), .result_src_e(result_src_e), .memwrite_e(memwrite_e),
        .jump_e(jump_e), .jalr_e(jalr_e), .branch_e(branch_e), .funct3_e(funct3_e),
        .alu_control_e(alu_control_e), .alu_src_e(alu_src_e),
        .rs1_data_e(rs1_data_e), .rs2_data_e(rs2_data_e),
        .pc_e(pc_e), .pc_plus_4_e(pc_plus_4_e), .immediate_e(immediate_e),
        .rd_e(rd_e), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .wb_result_w(wb_result_w), .flush_e(flush_e),
        .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .ex_busy(ex_busy),
        .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_writedata(ex_mem_writedata),
        .ex_mem_pc_plus_4(ex_mem_pc_plus_4), .ex_mem_rd(ex_mem_rd),
        .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_memwrite(ex_mem_memwrite),
        .ex_mem_result_src(ex_mem_result_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctl;
        logic        asrc;
        logic [1:0]  fa, fb;
        logic [31:0] rs1, rs2, imm, wb, pc;
        logic        jump, jalr, branch;
        logic [2:0]  f3;
        logic        flush, rw, mw;
        logic [31:0] e_alu, e_wd;
        logic        e_pcsrc;
        logic [31:0] e_tgt;
    } vec_t;

    typedef struct {
        logic [31:0] alu, wd, pc4;
        logic [4:0]  rd;
        logic        rw, mw;
        logic [1:0]  rs;
    } exp_t;

    localparam int NV = 26;
    vec_t vecs [NV];
    exp_t sb [$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(logic [3:0] ctl, logic asrc, logic [1:0] fa, logic [1:0] fb,
                                logic [31:0] rs1, logic [31:0] rs2, logic [31:0] imm,
                                logic [31:0] wb, logic [31:0] pc, logic jump, logic jalr,
                                logic branch, logic [2:0] f3, logic flush, logic rw, logic mw,
                                logic [31:0] e_alu, logic [31:0] e_wd, logic e_pcsrc,
                                logic [31:0] e_tgt);
        vec_t v;
        v.ctl = ctl; v.asrc = asrc; v.fa = fa; v.fb = fb;
        v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.wb = wb; v.pc = pc;
        v.jump = jump; v.jalr = jalr; v.branch = branch; v.f3 = f3;
        v.flush = flush; v.rw = rw; v.mw = mw;
        v.e_alu = e_alu; v.e_wd = e_wd; v.e_pcsrc = e_pcsrc; v.e_tgt = e_tgt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_bubble();
        exp_t e;
        e.alu = '0; e.wd = '0; e.pc4 = '0; e.rd = '0; e.rw = 1'b0; e.mw = 1'b0; e.rs = 2'b00;
        sb.push_back(e);
    endtask

    task automatic push_exp(input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                            input logic [4:0] rd, input logic rw, input logic mw,
                            input logic [1:0] rs);
        exp_t e;
        e.alu = alu; e.wd = wd; e.pc4 = pc4; e.rd = rd; e.rw = rw; e.mw = mw; e.rs = rs;
        sb.push_back(e);
    endtask

    // Wait for the next active edge, then compare EX/MEM against the oldest expectation.
    task automatic check_edge(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_alu"}, {32'd0, ex_mem_alu_result}, {32'd0, e.alu});
            chk({tag, "_wd"},  {32'd0, ex_mem_writedata},  {32'd0, e.wd});
            chk({tag, "_pc4"}, {32'd0, ex_mem_pc_plus_4},  {32'd0, e.pc4});
            chk({tag, "_rd"},  {59'd0, ex_mem_rd},         {59'd0, e.rd});
            chk({tag, "_rw"},  {63'd0, ex_mem_regwrite},   {63'd0, e.rw});
            chk({tag, "_mw"},  {63'd0, ex_mem_memwrite},   {63'd0, e.mw});
            chk({tag, "_rs"},  {62'd0, ex_mem_result_src}, {62'd0, e.rs});
            $display("txn %s: alu=0x%08h wd=0x%08h rd=%0d rw=%0b mw=%0b", tag,
                     ex_mem_alu_result, ex_mem_writedata, ex_mem_rd, ex_mem_regwrite,
                     ex_mem_memwrite);
        end
    endtask

    task automatic set_nop();
        regwrite_e = 0; memwrite_e = 0; jump_e = 0; jalr_e = 0; branch_e = 0;
        alu_src_e = 0; flush_e = 0; result_src_e = 0; forward_a_e = 0; forward_b_e = 0;
        funct3_e = 3'b010; alu_control_e = 4'b0000; rs1_data_e = 0; rs2_data_e = 0;
        pc_e = 0; pc_plus_4_e = 0; immediate_e = 0; wb_result_w = 0; rd_e = 0;
    endtask

    task automatic drive_alu(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                             input logic rw, input logic [4:0] rd);
        set_nop();
        alu_control_e = ctl; rs1_data_e = a; rs2_data_e = b; regwrite_e = rw; rd_e = rd;
        pc_e = 32'h100; pc_plus_4_e = 32'h104;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, {63'd0, ex_busy}, 64'd0);
        chk({tag, "_alu"},  {32'd0, ex_mem_alu_result}, 64'd0);
        chk({tag, "_wd"},   {32'd0, ex_mem_writedata}, 64'd0);
        chk({tag, "_pc4"},  {32'd0, ex_mem_pc_plus_4}, 64'd0);
        chk({tag, "_ctl"},  {56'd0, ex_mem_rd, ex_mem_regwrite, ex_mem_memwrite, ex_mem_result_src}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int busy_cnt;
        vec_t v;

        //            ctl    as fa     fb     rs1           rs2           imm       wb            pc      j  jr br f3      fl rw mw e_alu         e_wd          pcs e_tgt
        vecs[0]  = mk(4'h0, 1, 2'b00, 2'b00, 32'h3,        32'h0,        32'h4,    32'h0,        32'h40, 0, 0, 0, 3'b010, 0, 1, 0, 32'h7,        32'h0,        0, 32'h44);
        vecs[1]  = mk(4'h0, 0, 2'b10, 2'b00, 32'h0,        32'h5,        32'h0,    32'h0,        32'h40, 0, 0, 0, 3'b010, 0, 1, 0, 32'hC,        32'h5,        0, 32'h40);
        vecs[2]  = mk(4'h0, 1, 2'b00, 2'b01, 32'h100,      32'h0,        32'h8,    32'hDEADBEEF, 32'h40, 0, 0, 0, 3'b010, 0, 0, 1, 32'h108,      32'hDEADBEEF, 0, 32'h48);
        vecs[3]  = mk(4'h1, 0, 2'b00, 2'b00, 32'h5,        32'h7,        32'h0,    32'h0,        32'h40, 0, 0, 0, 3'b010, 0, 1, 0, 32'hFFFFFFFE, 32'h7,        0, 32'h40);
        vecs[4]  = mk(4'h2, 0, 2'b00, 2'b00, 32'hF0F01234, 32'h0FF0FF00, 32'h0,    32'h0,        32'h40, 0, 0, 0, 3'b010, 0, 1, 0, 32'h00F01200, 32'h0FF0FF00, 0, 32'h40);
        vecs[5]  = mk(4'h3, 0, 2'b00, 2'b00, 32'hF0F01234, 32'h0FF0FF00, 32'h0,    32'h0,        32'h40, 0, 0, 0, 3'b010, 0, 1, 0, 32'hFFF0FF34, 32'h0FF0FF00, 0, 32'h40);
        vecs[6]  = mk(4'h4, 0, 2'b00, 2'b00, 32'hF0F01234, 32'h0FF0FF00, 32'h0,    32'h0,        32'h40, 0, 0, 0, 3'b010, 0, 1, 0, 32'hFF00ED34, 32'h0FF0FF00, 0, 32'h40);
        vecs[7]  = mk(4'h5, 0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h1,        32'h0,    32'h0,        32'h40, 0, 0, 0, 3'b010, 0, 1, 0, 32'h1,        32'h1,        0, 32'h40);
        vecs[8]  = mk(4'h6, 0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h1,        32'h0,    32'h0,        32'h40, 0, 0, 0, 3'b010, 0, 1, 0, 32'h0,        32'h1,        0, 32'h40);
        vecs[9]  = mk(4'h7, 0, 2'b00, 2'b00, 32'h1,        32'h24,       32'h0,    32'h0,        32'h40, 0, 0, 0, 3'b010, 0, 1, 0, 32'h10,       32'h24,       0, 32'h40);
        vecs[10] = mk(4'h8, 0, 2'b00, 2'b00, 32'h80000000, 32'h1F,       32'h0,    32'h0,        32'h40, 0, 0, 0, 3'b010, 0, 1, 0, 32'h1,        32'h1F,       0, 32'h40);
        vecs[11] = mk(4'h9, 0, 2'b00, 2'b00, 32'h80000000, 32'h1F,       32'h0,    32'h0,        32'h40, 0, 0, 0, 3'b010, 0, 1, 0, 32'hFFFFFFFF, 32'h1F,       0, 32'h40);
        vecs[12] = mk(4'hB, 0, 2'b00, 2'b00, 32'h5,        32'h6,        32'h0,    32'h0,        32'h40, 0, 0, 0, 3'b010, 0, 1, 0, 32'h0,        32'h6,        0, 32'h40);
        vecs[13] = mk(4'h0, 0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h2,        32'h0,    32'h0,        32'h40, 0, 0, 0, 3'b010, 0, 1, 0, 32'h1,        32'h2,        0, 32'h40);
        vecs[14] = mk(4'h0, 0, 2'b11, 2'b11, 32'hA,        32'h1,        32'h0,    32'h99,       32'h40, 0, 0, 0, 3'b010, 0, 1, 0, 32'hB,        32'h1,        0, 32'h40);
        vecs[15] = mk(4'h1, 0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h1,        32'h10,   32'h0,        32'h40, 0, 0, 1, 3'b100, 0, 0, 0, 32'hFFFFFFFE, 32'h1,        1, 32'h50);
        vecs[16] = mk(4'h1, 0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h1,        32'h10,   32'h0,        32'h40, 0, 0, 1, 3'b110, 0, 0, 0, 32'hFFFFFFFE, 32'h1,        0, 32'h50);
        vecs[17] = mk(4'h1, 0, 2'b00, 2'b00, 32'h5,        32'h5,        32'h10,   32'h0,        32'h40, 0, 0, 1, 3'b000, 0, 0, 0, 32'h0,        32'h5,        1, 32'h50);
        vecs[18] = mk(4'h1, 0, 2'b00, 2'b00, 32'h5,        32'h5,        32'h10,   32'h0,        32'h40, 0, 0, 1, 3'b001, 0, 0, 0, 32'h0,        32'h5,        0, 32'h50);
        vecs[19] = mk(4'h1, 0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h1,        32'h10,   32'h0,        32'h40, 0, 0, 1, 3'b101, 0, 0, 0, 32'hFFFFFFFE, 32'h1,        0, 32'h50);
        vecs[20] = mk(4'h1, 0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h1,        32'h10,   32'h0,        32'h40, 0, 0, 1, 3'b111, 0, 0, 0, 32'hFFFFFFFE, 32'h1,        1, 32'h50);
        vecs[21] = mk(4'h1, 0, 2'b00, 2'b00, 32'h5,        32'h5,        32'h10,   32'h0,        32'h40, 0, 0, 1, 3'b010, 0, 0, 0, 32'h0,        32'h5,        0, 32'h50);
        vecs[22] = mk(4'h0, 1, 2'b00, 2'b00, 32'h203,      32'h0,        32'h4,    32'h0,        32'h40, 1, 1, 0, 3'b000, 0, 1, 0, 32'h44,       32'h0,        1, 32'h206);
        vecs[23] = mk(4'h0, 1, 2'b00, 2'b00, 32'h0,        32'h0,        32'h20,   32'h0,        32'h80, 1, 0, 0, 3'b000, 0, 1, 0, 32'h84,       32'h0,        1, 32'hA0);
        vecs[24] = mk(4'h0, 0, 2'b00, 2'b10, 32'h1,        32'h0,        32'h0,    32'h0,        32'h40, 0, 0, 0, 3'b010, 0, 1, 0, 32'h85,       32'h84,       0, 32'h40);
        vecs[25] = mk(4'h0, 0, 2'b00, 2'b00, 32'h1,        32'h1,        32'h0,    32'h0,        32'h40, 1, 0, 0, 3'b000, 1, 1, 1, 32'h0,        32'h0,        0, 32'h40);

        // Reset with a MUL on the inputs: stall must stay low, EX/MEM all zero.
        reset_n = 1'b0;
        drive_alu(4'hA, 32'h3, 32'h3, 1'b1, 5'd4);
        #3;
        check_reset_outputs("reset_init");
        set_nop();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            set_nop();
            alu_control_e = v.ctl; alu_src_e = v.asrc; forward_a_e = v.fa; forward_b_e = v.fb;
            rs1_data_e = v.rs1; rs2_data_e = v.rs2; immediate_e = v.imm; wb_result_w = v.wb;
            pc_e = v.pc; pc_plus_4_e = v.pc + 32'd4; jump_e = v.jump; jalr_e = v.jalr;
            branch_e = v.branch; funct3_e = v.f3; flush_e = v.flush; regwrite_e = v.rw;
            memwrite_e = v.mw; rd_e = 5'(i); result_src_e = 2'(i);
            if (v.flush) push_bubble();
            else push_exp(v.e_alu, v.e_wd, v.pc + 32'd4, 5'(i), v.rw, v.mw, 2'(i));
            #2;
            chk($sformatf("v%0d_pc_src", i), {63'd0, pc_src_e}, {63'd0, v.e_pcsrc});
            chk($sformatf("v%0d_target", i), {32'd0, pc_target_e}, {32'd0, v.e_tgt});
            chk($sformatf("v%0d_busy", i), {63'd0, ex_busy}, 64'd0);
            check_edge($sformatf("v%0d", i));
        end

        // MUL 0xFFFFFFFF * 3: stall for issue + 32 BUSY cycles, then one result.
        drive_alu(4'hA, 32'hFFFFFFFF, 32'h3, 1'b1, 5'd7);
        busy_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            #2;
            if (!ex_busy) break;
            busy_cnt++;
            push_bubble();
            check_edge($sformatf("mul_stall%0d", c));
        end
        chk("mul_busy_cycles", 64'(busy_cnt), 64'd33);
        chk("mul_done_pc_src", {63'd0, pc_src_e}, 64'd0);
        push_exp(32'hFFFFFFFD, 32'h3, 32'h104, 5'd7, 1'b1, 1'b0, 2'b00);
        check_edge("mul_result");
        drive_alu(4'h0, 32'h2, 32'h2, 1'b0, 5'd0);
        #2;
        chk("mul_after_busy", {63'd0, ex_busy}, 64'd0);
        push_exp(32'h4, 32'h2, 32'h104, 5'd0, 1'b0, 1'b0, 2'b00);
        check_edge("mul_after");

        // MUL killed by flush on the 10th BUSY cycle.
        drive_alu(4'hA, 32'h5, 32'h7, 1'b1, 5'd3);
        for (int c = 0; c < 10; c++) begin
            #2;
            chk($sformatf("flushmul_busy%0d", c), {63'd0, ex_busy}, 64'd1);
            push_bubble();
            check_edge($sformatf("flushmul_stall%0d", c));
        end
        flush_e = 1'b1;
        #2;
        chk("flushmul_busy_drop", {63'd0, ex_busy}, 64'd0);
        push_bubble();
        check_edge("flushmul_bubble");
        drive_alu(4'h0, 32'h5, 32'h7, 1'b1, 5'd3);
        #2;
        chk("flushmul_idle", {63'd0, ex_busy}, 64'd0);
        push_exp(32'hC, 32'h7, 32'h104, 5'd3, 1'b1, 1'b0, 2'b00);
        check_edge("flushmul_next");

        // Asynchronous reset clears a loaded EX/MEM register and gates the stall.
        drive_alu(4'h0, 32'h50, 32'h5, 1'b1, 5'd9);
        result_src_e = 2'b10;
        push_exp(32'h55, 32'h5, 32'h104, 5'd9, 1'b1, 1'b0, 2'b10);
        #2;
        check_edge("pre_reset");
        drive_alu(4'hA, 32'h1, 32'h1, 1'b1, 5'd2);
        #1;
        chk("rst_issue_busy", {63'd0, ex_busy}, 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) @(posedge clk);
        #2;
        chk("rst_midmul_busy", {63'd0, ex_busy}, 64'd1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_midmul");
        drive_alu(4'h0, 32'h20, 32'h3, 1'b1, 5'd6);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_release_idle", {63'd0, ex_busy}, 64'd0);
        push_exp(32'h23, 32'h3, 32'h104, 5'd6, 1'b1, 1'b0, 2'b00);
        check_edge("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
